// File: rtl/uart_echo_engine.sv
// Echo/record controller between the UART RX and TX FIFO handshakes.
// Optional build macro UART_ECHO_UPPER_EN: ASCII lower->upper on the TX path.
module uart_echo_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              dump,
    input  logic              clear,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_recv,
    input  logic              tx_full,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_send,
    output logic [DATA_W-1:0] last_byte,
    output logic [CNT_W-1:0]  count,
    output logic              buf_full,
    output logic              overflow,
    output logic              busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {IDLE, XFER, GAP, DPUSH, DGAP} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              dump_q, dump_req;
    logic              go_dump, go_xfer, wr_en, do_push;

    function automatic logic [DATA_W-1:0] tx_map(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = w;
`ifdef UART_ECHO_UPPER_EN
        if (w[7:0] >= 8'h61 && w[7:0] <= 8'h7A)
            r[5] = 1'b0;
`endif
        return r;
    endfunction

    assign dump_req = dump & ~dump_q;
    assign buf_full = (count == CNT_FULL);
    assign busy     = (state != IDLE);

    // IDLE arbitration: clear, then dump request, then RX word.
    assign go_dump = (state == IDLE) && !clear && dump_req && mode && (count != '0);
    assign go_xfer = (state == IDLE) && !clear && !go_dump && rx_ready && (mode || !tx_full);
    assign wr_en   = go_xfer && mode && !buf_full;

    // A dump push fires on every entry into DPUSH, and on retries while stalled there.
    assign do_push = !clear && !tx_full &&
                     (go_dump ||
                      (state == DPUSH && !tx_send) ||
                      (state == DGAP && count != '0));

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_recv   <= 1'b0;
            tx_send   <= 1'b0;
            tx_data   <= '0;
            last_byte <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dump_q    <= 1'b0;
        end else begin
            dump_q  <= dump;
            rx_recv <= 1'b0;
            tx_send <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go_dump) begin
                            state <= DPUSH;
                        end else if (go_xfer) begin
                            state     <= XFER;
                            rx_recv   <= 1'b1;
                            last_byte <= rx_data;
                            if (!mode) begin
                                tx_data <= tx_map(rx_data);
                                tx_send <= 1'b1;
                            end else if (!buf_full) begin
                                wr_ptr <= wr_ptr + PTR_ONE;
                                count  <= count + CNT_ONE;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    XFER:  state <= GAP;
                    GAP:   state <= IDLE;
                    DPUSH: if (tx_send) state <= DGAP;
                    DGAP:  state <= (count != '0) ? DPUSH : IDLE;
                    default: state <= IDLE;
                endcase
                if (do_push) begin
                    tx_data <= tx_map(mem[rd_ptr]);
                    tx_send <= 1'b1;
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    count   <= count - CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench for uart_echo_engine with a queue model of the UART RX FIFO.
module tb_uart_echo_engine;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          mode = 1'b0, dump = 1'b0, clear = 1'b0;
    logic          rx_ready = 1'b0, tx_full = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_recv, tx_send, buf_full, overflow, busy;
    logic [DW-1:0] tx_data, last_byte;
    logic [CW-1:0] count;

    int n_cmp = 0, n_err = 0, cyc = 0, pops = 0;
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] txlog[$];
    int txcyc[$];

    uart_echo_engine #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .dump(dump), .clear(clear),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_recv(rx_recv),
        .tx_full(tx_full), .tx_data(tx_data), .tx_send(tx_send),
        .last_byte(last_byte), .count(count), .buf_full(buf_full),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sync_rx;
        rx_ready = (fifo.size() > 0);
        rx_data  = rx_ready ? fifo[0] : '0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (rx_recv) begin
            pops++;
            if (fifo.size() > 0) fifo.delete(0);
        end
        if (tx_send) begin
            txlog.push_back(tx_data);
            txcyc.push_back(cyc);
        end
        sync_rx();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr_logs;
        txlog.delete();
        txcyc.delete();
        pops = 0;
    endtask

    function automatic logic [31:0] tx_at(input int i);
        return (i < txlog.size()) ? 32'(txlog[i]) : 32'hDEAD;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < txcyc.size()) ? txcyc[i] : -1000;
    endfunction

    initial begin
        int start, stall;
        bit stall_done;
        logic [31:0] exp_up;

        // reset values
        #12;
        chk("rst_rx_recv", 32'(rx_recv), 0);
        chk("rst_tx_send", 32'(tx_send), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_last", 32'(last_byte), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(buf_full), 0);
        @(negedge clk) rst_n = 1'b1;

        // async reset while rx_recv is high
        fifo.push_back(8'h55); sync_rx();
        tick();
        chk("mid_xfer_pulse", 32'(rx_recv), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rx_recv", 32'(rx_recv), 0);
        chk("arst_tx_send", 32'(tx_send), 0);
        chk("arst_tx_data", 32'(tx_data), 0);
        chk("arst_last", 32'(last_byte), 0);
        chk("arst_busy", 32'(busy), 0);
        fifo.delete(); sync_rx();
        @(negedge clk) rst_n = 1'b1;
        clr_logs();
        run(4);
        chk("rel_no_tx", 32'(txlog.size()), 0);
        chk("rel_no_pop", 32'(pops), 0);
        chk("rel_idle", 32'(busy), 0);

        // echo three words
        clr_logs();
        fifo.push_back(8'h41); fifo.push_back(8'h42); fifo.push_back(8'h43); sync_rx();
        start = cyc;
        run(12);
        chk("echo_n", 32'(txlog.size()), 3);
        chk("echo_w0", tx_at(0), 32'h41);
        chk("echo_w1", tx_at(1), 32'h42);
        chk("echo_w2", tx_at(2), 32'h43);
        chk("echo_lat", 32'(cyc_at(0) - start), 1);
        chk("echo_gap1", 32'(cyc_at(1) - cyc_at(0)), 3);
        chk("echo_gap2", 32'(cyc_at(2) - cyc_at(1)), 3);
        chk("echo_pops", 32'(pops), 3);
        chk("echo_last", 32'(last_byte), 32'h43);

        // lower-case letter on the echo path
        clr_logs();
        fifo.push_back(8'h61); sync_rx();
        run(4);
`ifdef UART_ECHO_UPPER_EN
        exp_up = 32'h41;
`else
        exp_up = 32'h61;
`endif
        chk("echo_case", tx_at(0), exp_up);
        chk("echo_case_last", 32'(last_byte), 32'h61);

        // TX back-pressure in echo mode
        clr_logs();
        tx_full = 1'b1;
        fifo.push_back(8'h5A); sync_rx();
        run(20);
        chk("bp_no_pop", 32'(pops), 0);
        chk("bp_no_tx", 32'(txlog.size()), 0);
        tx_full = 1'b0;
        run(2);
        chk("bp_release_n", 32'(txlog.size()), 1);
        chk("bp_release_w", tx_at(0), 32'h5A);
        run(3);

        // store 18 words into a 16-deep buffer
        mode = 1'b1;
        clr_logs();
        for (int i = 0; i < 18; i++) fifo.push_back(8'(8'h10 + i));
        sync_rx();
        run(60);
        chk("st_pops", 32'(pops), 18);
        chk("st_no_tx", 32'(txlog.size()), 0);
        chk("st_count", 32'(count), 16);
        chk("st_full", 32'(buf_full), 1);
        chk("st_ovf", 32'(overflow), 1);
        clr_logs();
        dump = 1'b1;
        run(40);
        chk("dmp_n", 32'(txlog.size()), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("dmp_w%0d", i), tx_at(i), 32'h10 + 32'(i));
        chk("dmp_count", 32'(count), 0);
        chk("dmp_ovf", 32'(overflow), 1);
        chk("dmp_idle", 32'(busy), 0);
        dump = 1'b0;
        tick();

        // dump with a TX stall and a second dump edge mid-dump
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) fifo.push_back(8'(8'hA0 + i));
        sync_rx();
        run(15);
        chk("s4_count", 32'(count), 4);
        clr_logs();
        dump = 1'b1;
        stall = 0;
        stall_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!stall_done && txlog.size() == 2) begin
                tx_full = 1'b1;
                stall = 5;
                stall_done = 1'b1;
            end else if (stall > 0) begin
                stall--;
                if (stall == 0) begin
                    chk("stall_hold", 32'(txlog.size()), 2);
                    tx_full = 1'b0;
                end
            end
            if (k == 3) dump = 1'b0;
            if (k == 5) begin
                dump = 1'b1;
                fifo.push_back(8'hB0); fifo.push_back(8'hB1); sync_rx();
            end
        end
        chk("s4_n", 32'(txlog.size()), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("s4_w%0d", i), tx_at(i), 32'hA0 + 32'(i));
        chk("s4_reedge_ign", 32'(count), 2);
        chk("s4_pops", 32'(pops), 2);
        chk("s4_idle", 32'(busy), 0);

        // clear aborts a dump after the first push
        dump = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        fifo.push_back(8'hC0); fifo.push_back(8'hC1); fifo.push_back(8'hC2); sync_rx();
        run(12);
        chk("s3_count", 32'(count), 3);
        clr_logs();
        dump = 1'b1;
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        run(10);
        chk("abort_n", 32'(txlog.size()), 1);
        chk("abort_w", tx_at(0), 32'hC0);
        chk("abort_count", 32'(count), 0);
        chk("abort_idle", 32'(busy), 0);
        dump = 1'b0; tick();
        dump = 1'b1; run(10);
        chk("abort_redump", 32'(txlog.size()), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_echo_engine.md
Name: uart_echo_engine

Overview:
Parametrised echo/record controller between the uart block's RX and TX FIFO handshakes. Replaces fixed single-shot echo logic. Two modes:
- Mode 0 (echo): each received word is sent straight back.
- Mode 1 (store): received words go into an internal circular buffer and are played back on a dump command.
Honours TX back-pressure and exposes last byte, fill count and overflow for the seven-segment display.

Parameters:
DATA_W, 8, word width of rx_data/tx_data
DEPTH, 16, store-buffer entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of count output (derived; do not override)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = echo, 1 = store; sampled only in IDLE
dump  in  1  level from button; rising edge requests playback
clear  in  1  synchronous: empty buffer, clear overflow, abort dump
rx_ready  in  1  UART RX FIFO non-empty; rx_data valid (show-ahead)
rx_data  in  DATA_W  head of UART RX FIFO
rx_recv  out  1  one-cycle pop pulse to UART RX FIFO
tx_full  in  1  UART TX FIFO full
tx_data  out  DATA_W  word to UART TX FIFO; registered
tx_send  out  1  one-cycle push pulse to UART TX FIFO
last_byte  out  DATA_W  most recent word popped from RX
count  out  CNT_W  words held in store buffer
buf_full  out  1  count == DEPTH
overflow  out  1  sticky: a word was dropped because the buffer was full
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; rx_recv, tx_send, tx_data, last_byte, count, overflow, busy, read/write pointers and dump edge register all 0. Buffer contents are not reset.
- dump edge: dump_q registered each cycle; dump_req = dump & ~dump_q. Edges arriving outside IDLE are discarded, not queued.
- FSM states: IDLE, XFER, GAP, DPUSH, DGAP. Every pulse is registered, lasts exactly one cycle, and is followed by one GAP/DGAP cycle so the UART flags settle before re-evaluation.
- IDLE priority:
  1. clear
  2. dump_req with mode=1 and count>0 -> DPUSH
  3. rx_ready, with (mode=1 or !tx_full) -> XFER
  4. otherwise stay in IDLE
- Entering XFER (same edge):
  - rx_recv <= 1 and last_byte <= rx_data.
  - mode 0: tx_data <= rx_data, tx_send <= 1.
  - mode 1: if count < DEPTH, write buffer[wr_ptr], advance wr_ptr, count+1; else drop the word and set overflow.
- XFER -> GAP unconditionally (pulses fall). GAP -> IDLE.
- Echo latency: rx_ready sampled high in cycle N -> rx_recv and tx_send high in N+1. Maximum throughput is one word per 3 cycles.
- Entering DPUSH: only when !tx_full. tx_data <= buffer[rd_ptr], tx_send <= 1, advance rd_ptr, count-1.
- In DPUSH: while tx_full, stay in DPUSH with tx_send low, retrying each cycle. RX is never popped during a dump; words wait in the UART FIFO.
- DPUSH (after a push) -> DGAP. DGAP -> DPUSH if count>0, else IDLE.
- Pointers are log2(DEPTH) bits and wrap naturally. Playback order is FIFO.
- clear in any state:
  - Next state IDLE; count, pointers and overflow go to 0.
  - A pulse already asserted this cycle completes.
  - A buffer write coincident with clear is discarded.
  - clear has priority over dump_req and rx_ready.
- A mode change mid-transfer or mid-dump takes effect on the next IDLE evaluation. Switching mode 1 -> 0 keeps buffer contents.
- buf_full and busy are combinational from count and state.

Optional Feature:
Macro UART_ECHO_UPPER_EN.
- Defined: a word on the TX path (echo and dump) in range 8'h61-8'h7A has bit 5 cleared (ASCII lower to upper) before being registered into tx_data. Stored buffer contents and last_byte stay raw. Upper bits beyond 8 pass unchanged when DATA_W > 8.
- Undefined: tx_data is the unmodified word.

Test Plan:
- Reset mid-XFER (rst_n low while rx_recv=1) -> all outputs 0 asynchronously; state IDLE after release; no pulse on release.
- Mode 0, RX FIFO holds 0x41,0x42,0x43, tx_full=0 -> three tx_send pulses, tx_data 0x41,0x42,0x43, each one cycle after the matching rx_ready sample, 3 cycles apart; last_byte=0x43. With UART_ECHO_UPPER_EN, input 0x61 -> tx_data 0x41.
- Mode 0, tx_full=1 with rx_ready=1 for 20 cycles -> no rx_recv and no tx_send; drop tx_full -> single echo within 2 cycles.
- Mode 1, DEPTH=16, 18 words received -> count=16, buf_full=1, overflow=1, 18 rx_recv pulses, no tx_send; dump edge -> first 16 words out in order, count returns to 0, overflow still 1.
- Mode 1, 4 words stored, dump edge, tx_full toggled high for 5 cycles after the 2nd push -> pushes pause then resume; all 4 words delivered, none duplicated; a second dump edge during the dump is ignored.
- Mode 1, 3 words stored, dump then clear after the first push -> one word transmitted, count=0, state IDLE, next dump edge produces no tx_send.
